// File: rtl/bsg_alu_resp.sv
// Handshaked ALU responder: valid/ready request in, 2-entry in-order valid/yumi result queue out.
// Latency 1 cycle (accept at edge N, result visible in cycle N+1); 1 op/cycle when consumed every cycle.
// Backpressure: ready_o drops when both queue entries are held; optional sticky overflow via BSG_ALU_RESP_STICKY_OV_EN.
module bsg_alu_resp #(
    parameter int width_p  = 4,
    parameter int harden_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [1:0]         control_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               v_o,
    output logic [width_p-1:0] res_o,
    output logic               ov_o,
    input  logic               yumi_i
`ifdef BSG_ALU_RESP_STICKY_OV_EN
    ,
    output logic               ov_sticky_o,
    input  logic               ov_clear_i
`endif
);

    typedef struct packed {
        logic [width_p-1:0] res;
        logic               ov;
    } entry_t;

    logic [width_p-1:0] res_n;
    logic               ov_n;

    // The hardened datapath shares one adder for add/sub and derives ov from msb carries.
    if (harden_p != 0) begin : g_hard
        logic               sub;
        logic [width_p-1:0] b_eff;
        logic [width_p:0]   sum_w;
        logic               c_msb;

        always_comb begin
            sub   = control_i[0];
            b_eff = sub ? ~b_i : b_i;
            sum_w = {1'b0, a_i} + {1'b0, b_eff} + {{width_p{1'b0}}, sub};
            c_msb = sum_w[width_p-1] ^ a_i[width_p-1] ^ b_eff[width_p-1];
            res_n = '0;
            ov_n  = 1'b0;
            if (control_i[1]) begin
                res_n = control_i[0] ? (a_i | b_i) : (a_i & b_i);
            end else begin
                res_n = sum_w[width_p-1:0];
                ov_n  = c_msb ^ sum_w[width_p];
            end
        end
    end else begin : g_soft
        always_comb begin
            res_n = '0;
            ov_n  = 1'b0;
            case (control_i)
                2'b00: begin
                    res_n = a_i + b_i;
                    ov_n  = (a_i[width_p-1] == b_i[width_p-1]) &&
                            (res_n[width_p-1] != a_i[width_p-1]);
                end
                2'b01: begin
                    res_n = a_i - b_i;
                    ov_n  = (a_i[width_p-1] != b_i[width_p-1]) &&
                            (res_n[width_p-1] != a_i[width_p-1]);
                end
                2'b10:   res_n = a_i & b_i;
                default: res_n = a_i | b_i;
            endcase
        end
    end

    entry_t     mem_q [2];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] cnt_q;
    logic       enq;
    logic       deq;
    entry_t     head;

    assign ready_o = (cnt_q != 2'd2) & ~reset_i;
    assign v_o     = (cnt_q != 2'd0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign head    = mem_q[rd_ptr_q];
    assign res_o   = head.res;
    assign ov_o    = head.ov;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (enq) begin
                mem_q[wr_ptr_q] <= '{res: res_n, ov: ov_n};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef BSG_ALU_RESP_STICKY_OV_EN
    logic ov_sticky_q;

    // A new overflow outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ov_sticky_q <= 1'b0;
        end else if (enq && ov_n) begin
            ov_sticky_q <= 1'b1;
        end else if (ov_clear_i) begin
            ov_sticky_q <= 1'b0;
        end
    end

    assign ov_sticky_o = ov_sticky_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
        end
    end

endmodule
